// File: rtl/csr_pkg.sv
// Shared CSR definitions for the machine-mode CSR responder: addresses, write masks,
// reset values, the write-operation encoding and small helpers.
package csr_pkg;

  // Implemented CSR addresses
  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMisa     = 12'h301;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMtval    = 12'h343;
  localparam logic [11:0] CsrMcycle   = 12'hB00;
  localparam logic [11:0] CsrMinstret = 12'hB02;
  localparam logic [11:0] CsrMcycleh  = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrMhartid  = 12'hF14;

  // Writable-bit masks
  localparam logic [31:0] MstatusMask = 32'h0000_0088;
  localparam logic [31:0] MtvecMask   = 32'hFFFF_FFFD;
  localparam logic [31:0] MepcMask    = 32'hFFFF_FFFC;
  localparam logic [31:0] FullMask    = 32'hFFFF_FFFF;

  // Reset / constant values
  localparam logic [31:0] MstatusMpp  = 32'h0000_1800;
  localparam logic [31:0] MstatusRst  = 32'h0000_1800;
  localparam logic [31:0] MisaValue   = 32'h4000_0100;

  typedef enum logic [1:0] {
    CsrOpRw   = 2'd0,
    CsrOpRs   = 2'd1,
    CsrOpRc   = 2'd2,
    CsrOpNone = 2'd3
  } csr_op_t;

  // Read-only region (addr[11:10] == 11) plus misa
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return (addr[11:10] == 2'b11) || (addr == CsrMisa);
  endfunction

  // Merge a candidate value into the old value through the writable mask
  function automatic logic [31:0] csr_apply(input logic [31:0] old_val,
                                            input logic [31:0] v,
                                            input logic [31:0] mask);
    return (old_val & ~mask) | (v & mask);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running/enabled counter with 32-bit half loads. A half load wins over the
// increment in the same cycle, so no carry reaches the other half that cycle.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wr_data_i,
  output logic [63:0] value_o
);

  logic [63:0] cnt_q, cnt_d;

  // Next count: half load has priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wr_data_i;
    end else if (wr_hi_i) begin
      cnt_d[63:32] = wr_data_i;
    end else if (en_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/csr_read_responder.sv
// Machine-mode CSR storage with a one-deep registered read responder, decoded CSR writes
// from commit, trap updates of mcause/mepc, and the mcycle/minstret counters.
module csr_read_responder
  import csr_pkg::*;
#(
  parameter int unsigned       XLEN    = 32,
  parameter logic [XLEN-1:0]   HART_ID = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [11:0]     req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_illegal,
  input  logic            wr_valid,
  input  logic [11:0]     wr_addr,
  input  logic [1:0]      wr_op,
  input  logic [XLEN-1:0] wr_data,
  output logic            wr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            instret_inc
);

  typedef enum logic {StEmpty, StFull} rsp_state_e;

  rsp_state_e      state_q, state_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_illegal_q, rsp_illegal_d;
  logic            wr_illegal_q, wr_illegal_d;

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  logic [63:0]     mcycle, minstret;
  logic            accept;
  logic [XLEN-1:0] rd_val;
  logic            rd_hit;
  logic [XLEN-1:0] wr_old, wr_mask, wr_v, wr_new;
  logic            wr_hit, wr_ro, wr_active, wr_zero_set, wr_bad, wr_do;
  csr_op_t         wr_op_e;

  assign wr_op_e = csr_op_t'(wr_op);

  // Read mux for the request address, using pre-update register values
  always_comb begin
    rd_val = '0;
    rd_hit = 1'b1;
    case (req_addr)
      CsrMstatus:   rd_val = mstatus_q;
      CsrMisa:      rd_val = MisaValue;
      CsrMtvec:     rd_val = mtvec_q;
      CsrMscratch:  rd_val = mscratch_q;
      CsrMepc:      rd_val = mepc_q;
      CsrMcause:    rd_val = mcause_q;
      CsrMtval:     rd_val = mtval_q;
      CsrMcycle:    rd_val = mcycle[31:0];
      CsrMcycleh:   rd_val = mcycle[63:32];
      CsrMinstret:  rd_val = minstret[31:0];
      CsrMinstreth: rd_val = minstret[63:32];
      CsrMhartid:   rd_val = HART_ID;
      default:      rd_hit = 1'b0;
    endcase
  end

  // Old value and writable mask for the write address
  always_comb begin
    wr_old  = '0;
    wr_mask = '0;
    wr_hit  = 1'b1;
    case (wr_addr)
      CsrMstatus:   begin wr_old = mstatus_q;       wr_mask = MstatusMask; end
      CsrMisa:      wr_old = MisaValue;
      CsrMtvec:     begin wr_old = mtvec_q;         wr_mask = MtvecMask;   end
      CsrMscratch:  begin wr_old = mscratch_q;      wr_mask = FullMask;    end
      CsrMepc:      begin wr_old = mepc_q;          wr_mask = MepcMask;    end
      CsrMcause:    begin wr_old = mcause_q;        wr_mask = FullMask;    end
      CsrMtval:     begin wr_old = mtval_q;         wr_mask = FullMask;    end
      CsrMcycle:    begin wr_old = mcycle[31:0];    wr_mask = FullMask;    end
      CsrMcycleh:   begin wr_old = mcycle[63:32];   wr_mask = FullMask;    end
      CsrMinstret:  begin wr_old = minstret[31:0];  wr_mask = FullMask;    end
      CsrMinstreth: begin wr_old = minstret[63:32]; wr_mask = FullMask;    end
      CsrMhartid:   wr_old = HART_ID;
      default:      wr_hit = 1'b0;
    endcase
  end

  // Write legality and new-value computation; a trap in the same cycle drops the write
  always_comb begin
    wr_ro       = csr_is_ro(wr_addr);
    wr_active   = wr_valid && (wr_op_e != CsrOpNone) && !trap_valid;
    // RS/RC with a zero operand is a pure read and may target read-only CSRs
    wr_zero_set = ((wr_op_e == CsrOpRs) || (wr_op_e == CsrOpRc)) && (wr_data == '0);
    wr_bad      = wr_active && (!wr_hit || (wr_ro && !wr_zero_set));
    wr_do       = wr_active && !wr_bad && !wr_ro;
    case (wr_op_e)
      CsrOpRw: wr_v = wr_data;
      CsrOpRs: wr_v = wr_old | wr_data;
      CsrOpRc: wr_v = wr_old & ~wr_data;
      default: wr_v = wr_old;
    endcase
    wr_new       = csr_apply(wr_old, wr_v, wr_mask);
    wr_illegal_d = wr_bad;
  end

  // CSR next-state: trap first, then decoded write
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_valid) begin
      mcause_d = trap_cause;
      mepc_d   = trap_pc & MepcMask;
    end else if (wr_do) begin
      case (wr_addr)
        CsrMstatus:  mstatus_d  = wr_new | MstatusMpp;
        CsrMtvec:    mtvec_d    = wr_new;
        CsrMscratch: mscratch_d = wr_new;
        CsrMepc:     mepc_d     = wr_new;
        CsrMcause:   mcause_d   = wr_new;
        CsrMtval:    mtval_d    = wr_new;
        default:     ;
      endcase
    end
  end

  // CSR storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q  <= MstatusRst;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (1'b1),
    .wr_lo_i   (wr_do && (wr_addr == CsrMcycle)),
    .wr_hi_i   (wr_do && (wr_addr == CsrMcycleh)),
    .wr_data_i (wr_new),
    .value_o   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (instret_inc),
    .wr_lo_i   (wr_do && (wr_addr == CsrMinstret)),
    .wr_hi_i   (wr_do && (wr_addr == CsrMinstreth)),
    .wr_data_i (wr_new),
    .value_o   (minstret)
  );

  // Response stage handshake and next state
  always_comb begin
    req_ready     = (state_q == StEmpty) || rsp_ready;
    accept        = req_valid && req_ready;
    state_d       = state_q;
    rsp_data_d    = rsp_data_q;
    rsp_illegal_d = rsp_illegal_q;
    if (accept) begin
      state_d       = StFull;
      rsp_data_d    = rd_hit ? rd_val : '0;
      rsp_illegal_d = !rd_hit;
    end else if ((state_q == StFull) && rsp_ready) begin
      state_d = StEmpty;
    end
  end

  // Response FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StEmpty;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
      wr_illegal_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rsp_data_q    <= rsp_data_d;
      rsp_illegal_q <= rsp_illegal_d;
      wr_illegal_q  <= wr_illegal_d;
    end
  end

  assign rsp_valid   = (state_q == StFull);
  assign rsp_data    = rsp_data_q;
  assign rsp_illegal = rsp_illegal_q;
  assign wr_illegal  = wr_illegal_q;

endmodule

// File: tb/tb_csr_read_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared against
// a cycle-level behavioural model built from address-keyed tables and 64-bit counters.
module tb_csr_read_responder;

  localparam logic [31:0] Hart = 32'h0000_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_illegal;
  logic        wr_valid = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [1:0]  wr_op = 2'd3;
  logic [31:0] wr_data = '0;
  logic        wr_illegal;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic        instret_inc = 1'b0;

  always #5 clk = ~clk;

  csr_read_responder #(
    .XLEN    (32),
    .HART_ID (Hart)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_illegal (rsp_illegal),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_op       (wr_op),
    .wr_data     (wr_data),
    .wr_illegal  (wr_illegal),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .instret_inc (instret_inc)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit [31:0] m_reg [bit [11:0]];
  bit [31:0] m_msk [bit [11:0]];
  bit [63:0] m_cyc, m_ins;
  bit        m_full, m_rill, m_wrill, m_cyc_wr, m_ins_wr;
  bit [31:0] m_rdata;

  bit [11:0] addr_pool [16] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14,
                                12'h7C0, 12'h344, 12'hFC0, 12'h000};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_reg.delete();
    m_msk.delete();
    m_reg[12'h300] = 32'h0000_1800; m_msk[12'h300] = 32'h0000_0088;
    m_reg[12'h305] = 32'h0;         m_msk[12'h305] = 32'hFFFF_FFFD;
    m_reg[12'h340] = 32'h0;         m_msk[12'h340] = 32'hFFFF_FFFF;
    m_reg[12'h341] = 32'h0;         m_msk[12'h341] = 32'hFFFF_FFFC;
    m_reg[12'h342] = 32'h0;         m_msk[12'h342] = 32'hFFFF_FFFF;
    m_reg[12'h343] = 32'h0;         m_msk[12'h343] = 32'hFFFF_FFFF;
    m_cyc = '0; m_ins = '0;
    m_full = 0; m_rill = 0; m_wrill = 0; m_rdata = '0;
  endtask

  task automatic model_read(input bit [11:0] a, output bit [31:0] d, output bit hit);
    hit = 1;
    d   = '0;
    if (m_reg.exists(a)) d = m_reg[a];
    else if (a == 12'h301) d = 32'h4000_0100;
    else if (a == 12'hF14) d = Hart;
    else if (a == 12'hB00) d = m_cyc[31:0];
    else if (a == 12'hB80) d = m_cyc[63:32];
    else if (a == 12'hB02) d = m_ins[31:0];
    else if (a == 12'hB82) d = m_ins[63:32];
    else hit = 0;
  endtask

  task automatic model_write(input bit [11:0] a, input bit [1:0] op, input bit [31:0] data,
                             output bit ill);
    bit [31:0] old, v;
    bit hit, ro;
    ill = 0;
    if (op == 2'd3) return;
    model_read(a, old, hit);
    ro = (a[11:10] == 2'b11) || (a == 12'h301);
    if (!hit) begin ill = 1; return; end
    if (ro) begin
      ill = !((op == 2'd1 || op == 2'd2) && data == 0);
      return;
    end
    v = (op == 2'd0) ? data : (op == 2'd1) ? (old | data) : (old & ~data);
    if (m_reg.exists(a)) m_reg[a] = (old & ~m_msk[a]) | (v & m_msk[a]);
    else if (a == 12'hB00) begin m_cyc[31:0]  = v; m_cyc_wr = 1; end
    else if (a == 12'hB80) begin m_cyc[63:32] = v; m_cyc_wr = 1; end
    else if (a == 12'hB02) begin m_ins[31:0]  = v; m_ins_wr = 1; end
    else if (a == 12'hB82) begin m_ins[63:32] = v; m_ins_wr = 1; end
  endtask

  // One clock: drive at negedge, check req_ready, advance model, check outputs at next negedge
  task automatic cycle(input bit rv, input bit [11:0] ra, input bit rr,
                       input bit wv, input bit [11:0] wa, input bit [1:0] wo,
                       input bit [31:0] wd, input bit tv, input bit [31:0] tc,
                       input bit [31:0] tp, input bit inc);
    bit [31:0] d;
    bit hit, acc, ill;
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    wr_valid = wv; wr_addr = wa; wr_op = wo; wr_data = wd;
    trap_valid = tv; trap_cause = tc; trap_pc = tp; instret_inc = inc;
    #1;
    check_val("req_ready", 32'(req_ready), 32'(!m_full || rr));
    acc = rv && (!m_full || rr);
    if (acc) begin
      model_read(ra, d, hit);
      m_full = 1; m_rdata = hit ? d : 32'h0; m_rill = !hit;
    end else if (rr) begin
      m_full = 0;
    end
    m_cyc_wr = 0; m_ins_wr = 0;
    if (tv) begin
      m_reg[12'h342] = tc;
      m_reg[12'h341] = tp & 32'hFFFF_FFFC;
      m_wrill = 0;
    end else if (wv) begin
      model_write(wa, wo, wd, ill);
      m_wrill = ill;
    end else begin
      m_wrill = 0;
    end
    if (!m_cyc_wr) m_cyc = m_cyc + 64'd1;
    if (!m_ins_wr && inc) m_ins = m_ins + 64'd1;
    @(posedge clk);
    @(negedge clk);
    check_val("rsp_valid", 32'(rsp_valid), 32'(m_full));
    check_val("wr_illegal", 32'(wr_illegal), 32'(m_wrill));
    if (m_full) begin
      check_val("rsp_data", rsp_data, m_rdata);
      check_val("rsp_illegal", 32'(rsp_illegal), 32'(m_rill));
    end
  endtask

  task automatic rd(input bit [11:0] a, input bit rr);
    cycle(1, a, rr, 0, 12'h0, 2'd3, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input bit [11:0] a, input bit [1:0] op, input bit [31:0] d);
    cycle(0, 12'h0, 1, 1, a, op, d, 0, 0, 0, 0);
  endtask

  task automatic idle();
    cycle(0, 12'h0, 1, 0, 12'h0, 2'd3, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check_val({tag, "_rsp_data"}, rsp_data, 32'h0);
    check_val({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'h0);
    check_val({tag, "_wr_illegal"}, 32'(wr_illegal), 32'h0);
  endtask

  function automatic bit [11:0] pick_addr();
    return addr_pool[$urandom_range(0, 15)];
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_outputs("reset");

    // minstret after 5 retire pulses
    repeat (5) cycle(0, 12'h0, 1, 0, 12'h0, 2'd3, 0, 0, 0, 0, 1);
    rd(12'hB02, 1);
    check_val("minstret5", rsp_data, 32'd5);

    // Back-to-back reads of reset values
    rd(12'h300, 1); check_val("mstatus_rst", rsp_data, 32'h0000_1800);
    rd(12'h301, 1); check_val("misa", rsp_data, 32'h4000_0100);
    rd(12'hF14, 1); check_val("mhartid", rsp_data, Hart);
    check_val("mhartid_ill", 32'(rsp_illegal), 32'h0);

    // mepc masking and RC
    wr(12'h341, 2'd0, 32'hFFFF_FFFF);
    rd(12'h341, 1); check_val("mepc_rw", rsp_data, 32'hFFFF_FFFC);
    wr(12'h341, 2'd2, 32'h0000_000C);
    rd(12'h341, 1); check_val("mepc_rc", rsp_data, 32'hFFFF_FFF0);

    // Illegal read and illegal write
    rd(12'h7C0, 1);
    check_val("ill_rd_flag", 32'(rsp_illegal), 32'h1);
    check_val("ill_rd_data", rsp_data, 32'h0);
    wr(12'hF14, 2'd0, 32'h0);
    check_val("ill_wr_pulse", 32'(wr_illegal), 32'h1);
    rd(12'hF14, 1); check_val("mhartid_keep", rsp_data, Hart);
    wr(12'h301, 2'd1, 32'h0);
    check_val("ro_rs0_nopulse", 32'(wr_illegal), 32'h0);

    // Backpressure: response held, req_ready low, then same-cycle re-accept
    wr(12'h340, 2'd0, 32'h55);
    rd(12'h340, 0);
    for (int i = 0; i < 3; i++) begin
      rd(12'h340, 0);
      check_val("bp_req_ready", 32'(req_ready), 32'h0);
      check_val("bp_data", rsp_data, 32'h55);
    end
    // Release together with same-cycle write of 0xAA: new response still reads 0x55
    cycle(1, 12'h340, 1, 1, 12'h340, 2'd0, 32'hAA, 0, 0, 0, 0);
    check_val("same_cyc_rd", rsp_data, 32'h55);
    rd(12'h340, 1); check_val("after_wr_rd", rsp_data, 32'hAA);

    // Trap beats a write to mcause
    cycle(0, 12'h0, 1, 1, 12'h342, 2'd0, 32'h99, 1, 32'h2, 32'h1237, 0);
    check_val("trap_nopulse", 32'(wr_illegal), 32'h0);
    rd(12'h342, 1); check_val("trap_mcause", rsp_data, 32'h2);
    rd(12'h341, 1); check_val("trap_mepc", rsp_data, 32'h1234);

    // Counter half writes and carry
    wr(12'hB00, 2'd0, 32'hFFFF_FFFF);
    wr(12'hB80, 2'd0, 32'h0);
    idle();
    rd(12'hB80, 1); check_val("mcycleh_carry", rsp_data, 32'h1);

    // 64-bit wrap
    wr(12'hB80, 2'd0, 32'hFFFF_FFFF);
    wr(12'hB00, 2'd0, 32'hFFFF_FFFF);
    rd(12'hB80, 1); check_val("wrap_before", rsp_data, 32'hFFFF_FFFF);
    rd(12'hB80, 1); check_val("wrap_after", rsp_data, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bit [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cycle(($urandom_range(0, 9) < 7), pick_addr(), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 2) == 0), pick_addr(), 2'($urandom_range(0, 3)), d,
            ($urandom_range(0, 15) == 0), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset with a response pending discards it
    rd(12'h340, 0);
    req_valid = 0; wr_valid = 0; trap_valid = 0; instret_inc = 0; rsp_ready = 0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rd(12'h300, 1); check_val("post_rst_mstatus", rsp_data, 32'h0000_1800);
    rd(12'h340, 1); check_val("post_rst_mscratch", rsp_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
